// File: rtl/bt_cmd_stream_encoder.sv
// Encodes one AT-style command frame (prefix, hex payload, optional CRLF)
// into a byte stream with valid/ready handshaking.
module bt_cmd_stream_encoder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned APPEND_CRLF = 1,
  parameter int unsigned LOWER_HEX   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_data,
  input  logic [3:0]        command_select,
  input  logic              start,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned NIB   = DATA_W / 4;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {IDLE, PREFIX, PAYLOAD, SUFFIX, DONE, ERR} state_t;

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   pos, nxt_pos;
  logic [3:0]         cmd_q, nxt_cmd;
  logic [DATA_W-1:0]  data_q, nxt_data;
  logic               fire;
  logic               nxt_valid;
  logic [7:0]         nxt_byte;

  // Prefix strings stored left-justified so byte p sits at bits [63-8p -: 8].
  function automatic logic [7:0] prefix_byte(input logic [3:0] cmd, input logic [2:0] p);
    logic [63:0] s;
    case (cmd)
      4'd1:    s = "AT+NAME=";
      4'd2:    s = {"AT+PIN=", 8'h00};
      4'd3:    s = "AT+BAUD=";
      4'd4:    s = "AT+RESET";
      default: s = {"AT", 48'h0};
    endcase
    return s[8 * (7 - int'(p)) +: 8];
  endfunction

  function automatic logic [CNT_W-1:0] prefix_last(input logic [3:0] cmd);
    case (cmd)
      4'd0:    return CNT_W'(1);
      4'd2:    return CNT_W'(6);
      default: return CNT_W'(7);
    endcase
  endfunction

  function automatic logic [7:0] hex_byte(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return ((LOWER_HEX != 0) ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] byte_at(input state_t s, input logic [CNT_W-1:0] p,
                                         input logic [3:0] cmd, input logic [DATA_W-1:0] d);
    case (s)
      PREFIX:  return prefix_byte(cmd, p[2:0]);
      PAYLOAD: return hex_byte(4'(d >> (4 * (NIB - 1 - 32'(p)))));
      SUFFIX:  return (p == '0) ? 8'h0D : 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  assign fire = tx_valid && tx_ready;

  // Next state / position; the frame only advances on an accepted byte.
  always_comb begin
    nxt_state = state;
    nxt_pos   = pos;
    nxt_cmd   = cmd_q;
    nxt_data  = data_q;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_cmd   = command_select;
          nxt_data  = input_data;
          nxt_pos   = '0;
          nxt_state = (command_select <= 4'd4) ? PREFIX : ERR;
        end
      end
      PREFIX: begin
        if (fire) begin
          if (pos == prefix_last(cmd_q)) begin
            nxt_pos = '0;
            if (cmd_q >= 4'd1 && cmd_q <= 4'd3) nxt_state = PAYLOAD;
            else if (APPEND_CRLF != 0)          nxt_state = SUFFIX;
            else                                nxt_state = DONE;
          end else begin
            nxt_pos = pos + CNT_W'(1);
          end
        end
      end
      PAYLOAD: begin
        if (fire) begin
          if (pos == CNT_W'(NIB - 1)) begin
            nxt_pos   = '0;
            nxt_state = (APPEND_CRLF != 0) ? SUFFIX : DONE;
          end else begin
            nxt_pos = pos + CNT_W'(1);
          end
        end
      end
      SUFFIX: begin
        if (fire) begin
          if (pos == '0) begin
            nxt_pos = CNT_W'(1);
          end else begin
            nxt_pos   = '0;
            nxt_state = DONE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    nxt_valid = (nxt_state == PREFIX) || (nxt_state == PAYLOAD) || (nxt_state == SUFFIX);
    nxt_byte  = nxt_valid ? byte_at(nxt_state, nxt_pos, nxt_cmd, nxt_data) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pos      <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= nxt_state;
      pos      <= nxt_pos;
      cmd_q    <= nxt_cmd;
      data_q   <= nxt_data;
      tx_data  <= nxt_byte;
      tx_valid <= nxt_valid;
      busy     <= (nxt_state != IDLE);
      done     <= (nxt_state == DONE);
      error    <= (nxt_state == ERR);
    end
  end

endmodule
